// File: rtl/if_fetch_unit_if.sv
// Instruction-memory fetch bus: one word per req/ack.
// Master drives req/addr, slave returns ack/rdata.
interface if_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/if_fetch_unit.sv
// Fetch stage: owns the PC, fetches one word at a time,
// holds it in IR until retire, then forms the next PC.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  if_fetch_unit_if.master imem,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [5:0]  INSTop,
  output logic [5:0]  funct,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic [1:0]  AddrSrc,
  input  logic        branch_taken,
  input  logic [31:0] reg_target,
  input  logic        retire,
  output logic        misalign_err,
  output logic [31:0] fetch_count
);

  typedef enum logic {
    S_FETCH,
    S_ISSUE
  } state_t;

  state_t      state;
  logic        req;
  logic [31:0] next_pc;
  logic [31:0] br_off;

  assign imem.imem_req  = req;
  assign imem.imem_addr = pc;

  assign pc_plus4 = pc + 32'd4;
  assign br_off   = {{14{instr[15]}}, instr[15:0], 2'b00};
  assign INSTop   = instr_valid ? instr[31:26] : 6'd0;
  assign funct    = instr_valid ? instr[5:0] : 6'd0;

  // Next-PC selection from CTRL's AddrSrc at retire time.
  always_comb begin
    next_pc = pc_plus4;
    unique case (AddrSrc)
      2'b00: next_pc = pc_plus4;
      2'b01: next_pc = branch_taken ? pc_plus4 + br_off
                                    : pc_plus4;
      2'b10: next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
      2'b11: next_pc = {reg_target[31:2], 2'b00};
    endcase
  end

  // Fetch/issue sequencer; req is registered so it drops
  // the cycle after reset and rises the cycle after retire.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_FETCH;
      pc           <= RESET_PC;
      instr        <= NOP_WORD;
      instr_valid  <= 1'b0;
      req          <= 1'b0;
      misalign_err <= 1'b0;
      fetch_count  <= 32'd0;
    end else begin
      unique case (state)
        S_FETCH: begin
          if (!req) begin
            req <= 1'b1;
          end else if (imem.imem_ack) begin
            instr       <= imem.imem_rdata;
            instr_valid <= 1'b1;
            fetch_count <= fetch_count + 32'd1;
            req         <= 1'b0;
            state       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (retire) begin
            pc          <= next_pc;
            instr       <= NOP_WORD;
            instr_valid <= 1'b0;
            req         <= 1'b1;
            state       <= S_FETCH;
            if (AddrSrc == 2'b11 && reg_target[1:0] != 2'b00)
              misalign_err <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed spec cases then
// randomized fetch/retire against a PC model.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic [31:0] instr;
  logic [5:0]  INSTop;
  logic [5:0]  funct;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [1:0]  AddrSrc;
  logic        branch_taken;
  logic [31:0] reg_target;
  logic        retire;
  logic        misalign_err;
  logic [31:0] fetch_count;

  int total = 0;
  int bad   = 0;

  logic [31:0] mpc;
  logic [31:0] minstr;
  logic        mvalid;
  logic [31:0] mcount;
  logic        mmis;

  if_fetch_unit_if imem ();

  if_fetch_unit dut (
    .clk          (clk),
    .rst          (rst),
    .imem         (imem.master),
    .instr_valid  (instr_valid),
    .instr        (instr),
    .INSTop       (INSTop),
    .funct        (funct),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .AddrSrc      (AddrSrc),
    .branch_taken (branch_taken),
    .reg_target   (reg_target),
    .retire       (retire),
    .misalign_err (misalign_err),
    .fetch_count  (fetch_count)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_next(
      input logic [1:0] src, input logic taken,
      input logic [31:0] tgt);
    int off;
    off = int'($signed(minstr[15:0]));
    case (src)
      2'd0: return mpc + 32'd4;
      2'd1: return taken ? mpc + 32'(4 + off * 4)
                         : mpc + 32'd4;
      2'd2: return ((mpc + 32'd4) & 32'hF000_0000)
                 | ((minstr & 32'h03FF_FFFF) << 2);
      default: return tgt & 32'hFFFF_FFFC;
    endcase
  endfunction

  task automatic model_reset();
    mpc    = 32'h0000_3000;
    minstr = 32'd0;
    mvalid = 1'b0;
    mcount = 32'd0;
    mmis   = 1'b0;
  endtask

  task automatic chk_reset_state();
    chk("rst_req", imem.imem_req, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_instr", instr, 0);
    chk("rst_pc", pc, 32'h3000);
    chk("rst_count", fetch_count, 0);
    chk("rst_mis", misalign_err, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    imem.imem_ack = 1'b0;
    retire = 1'b0;
    @(negedge clk);
    @(negedge clk);
    model_reset();
    chk_reset_state();
    rst = 1'b0;
  endtask

  // Wait for req, stall `waits` cycles (stray retires
  // must be ignored), then ack with `word`.
  task automatic fetch(input logic [31:0] word,
                       input int waits);
    int n = 0;
    while (imem.imem_req !== 1'b1 && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk("req_up", imem.imem_req, 1);
    for (int i = 0; i < waits; i++) begin
      chk("addr_hold", imem.imem_addr, mpc);
      retire     = 1'($urandom_range(0, 1));
      AddrSrc    = 2'($urandom);
      reg_target = $urandom;
      @(negedge clk);
    end
    retire = 1'b0;
    chk("addr_ack", imem.imem_addr, mpc);
    imem.imem_ack   = 1'b1;
    imem.imem_rdata = word;
    @(negedge clk);
    imem.imem_ack   = 1'b0;
    imem.imem_rdata = $urandom;
    minstr = word;
    mvalid = 1'b1;
    mcount = mcount + 32'd1;
    chk("f_valid", instr_valid, 1);
    chk("f_instr", instr, minstr);
    chk("f_op", INSTop, minstr >> 26);
    chk("f_funct", funct, minstr & 32'h3F);
    chk("f_count", fetch_count, mcount);
    chk("f_pc", pc, mpc);
    chk("f_pc4", pc_plus4, mpc + 32'd4);
    chk("f_req", imem.imem_req, 0);
  endtask

  // One idle cycle with a stray ack, then retire.
  task automatic do_retire(input logic [1:0] src,
                           input logic taken,
                           input logic [31:0] tgt);
    logic [31:0] exp;
    imem.imem_ack   = 1'b1;
    imem.imem_rdata = ~minstr;
    @(negedge clk);
    chk("hold_instr", instr, minstr);
    chk("hold_count", fetch_count, mcount);
    AddrSrc      = src;
    branch_taken = taken;
    reg_target   = tgt;
    retire       = 1'b1;
    exp = model_next(src, taken, tgt);
    if (src == 2'd3 && (tgt % 4) != 0)
      mmis = 1'b1;
    @(negedge clk);
    retire        = 1'b0;
    imem.imem_ack = 1'b0;
    mpc    = exp;
    minstr = 32'd0;
    mvalid = 1'b0;
    chk("r_valid", instr_valid, 0);
    chk("r_instr", instr, 0);
    chk("r_op", INSTop, 0);
    chk("r_req", imem.imem_req, 1);
    chk("r_addr", imem.imem_addr, mpc);
    chk("r_mis", misalign_err, mmis);
  endtask

  logic [31:0] brw;

  initial begin
    rst             = 1'b1;
    imem.imem_ack   = 1'b0;
    imem.imem_rdata = 32'd0;
    AddrSrc         = 2'd0;
    branch_taken    = 1'b0;
    reg_target      = 32'd0;
    retire          = 1'b0;
    model_reset();

    do_reset();
    fetch(32'h2008_0005, 3);
    chk("op_08", INSTop, 6'h08);
    chk("count_1", fetch_count, 1);

    brw = {6'h04, 10'h000, 16'hFFFC};
    do_retire(2'd3, 1'b0, 32'h0000_3010);
    fetch(brw, 1);
    do_retire(2'd1, 1'b1, 32'd0);
    chk("br_taken", imem.imem_addr, 32'h3004);
    fetch(32'h0000_0020, 0);
    do_retire(2'd3, 1'b0, 32'h0000_3010);
    fetch(brw, 2);
    do_retire(2'd1, 1'b0, 32'd0);
    chk("br_not", imem.imem_addr, 32'h3014);

    do_reset();
    fetch({6'h02, 26'h000_0C08}, 0);
    do_retire(2'd2, 1'b1, 32'd0);
    chk("jump", imem.imem_addr, 32'h0000_3020);

    fetch(32'h0000_0008, 1);
    do_retire(2'd3, 1'b0, 32'h0000_3007);
    chk("jr_addr", imem.imem_addr, 32'h3004);
    chk("jr_mis", misalign_err, 1);
    fetch(32'h1234_5678, 2);
    do_retire(2'd0, 1'b0, 32'd0);
    chk("mis_sticky", misalign_err, 1);

    rst             = 1'b1;
    imem.imem_ack   = 1'b1;
    imem.imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    model_reset();
    chk("mid_instr", instr, 0);
    chk("mid_valid", instr_valid, 0);
    chk("mid_pc", pc, 32'h3000);
    chk("mid_req", imem.imem_req, 0);
    chk("mid_mis", misalign_err, 0);
    rst           = 1'b0;
    imem.imem_ack = 1'b0;

    fetch(32'hAAAA_0001, 0);
    do_retire(2'd3, 1'b0, 32'hFFFF_FFFC);
    fetch(32'h0C00_0001, 0);
    do_retire(2'd0, 1'b0, 32'd0);
    chk("wrap", imem.imem_addr, 32'h0);
    fetch(32'h0000_0003, 0);

    for (int k = 0; k < 40; k++) begin
      do_retire(2'($urandom), 1'($urandom),
                $urandom);
      fetch($urandom, $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
